// File: rtl/cl2_pl_exu_pkg.sv
// cl2_pl_exu_pkg: shared widths, write-back arbiter states and write request type
package cl2_pl_exu_pkg;
  localparam int XLEN = 32;
  localparam int REG_NUM = 32;
  localparam int REG_W = $clog2(REG_NUM);
  typedef enum logic [1:0] {ARB_NORM, ARB_BLOCK, ARB_LSU} wb_arb_state_e;
  typedef struct packed {
    logic             wen;
    logic [REG_W-1:0] idx;
    logic [XLEN-1:0]  dat;
  } wb_req_t;
endpackage

// File: rtl/cl2_pl_exu_scoreboard.sv
// cl2_pl_exu_scoreboard: per-register pending bits with one set, one clear and three lookups
module cl2_pl_exu_scoreboard
    import cl2_pl_exu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    input  logic [REG_W-1:0] rs1_idx,
    input  logic [REG_W-1:0] rs2_idx,
    input  logic [REG_W-1:0] rd_idx,
    output logic             rs1_pend,
    output logic             rs2_pend,
    output logic             rd_pend
);
    logic [REG_NUM-1:0] pending, set_mask, clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        set_mask[set_idx] = set_en;
        clr_mask[clr_idx] = clr_en;
    end

    // x0 is never tracked, so its bit is forced low on every update
    always_ff @(posedge clk) begin
        if (rst)
            pending <= '0;
        else
            pending <= ((pending & ~clr_mask) | set_mask) & ~REG_NUM'(1);
    end

    assign rs1_pend = pending[rs1_idx];
    assign rs2_pend = pending[rs2_idx];
    assign rd_pend  = pending[rd_idx];
endmodule

// File: rtl/cl2_pl_exu_wb_ctrl.sv
// cl2_pl_exu_wb_ctrl: regfile write-port scheduler for ALU and LSU/MDU results
// with hazard-gated issue and LSU anti-starvation.
module cl2_pl_exu_wb_ctrl
    import cl2_pl_exu_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int LONG_OUTST = 2
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             iss_valid_i,
    output logic             iss_ready_o,
    input  logic [REG_W-1:0] iss_rs1_idx_i,
    input  logic [REG_W-1:0] iss_rs2_idx_i,
    input  logic             iss_rd_wen_i,
    input  logic [REG_W-1:0] iss_rd_idx_i,
    input  logic             iss_long_i,
    input  logic             alu_wb_valid_i,
    input  logic [REG_W-1:0] alu_wb_idx_i,
    input  logic [XLEN-1:0]  alu_wb_dat_i,
    input  logic             lsu_wb_valid_i,
    output logic             lsu_wb_ready_o,
    input  logic [REG_W-1:0] lsu_wb_idx_i,
    input  logic [XLEN-1:0]  lsu_wb_dat_i,
    output logic             wd_wen_o,
    output logic [REG_W-1:0] wd_idx_o,
    output logic [XLEN-1:0]  wd_dat_o
);
    localparam int LC_W = $clog2(LONG_OUTST + 1);
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    wb_arb_state_e   state, state_nxt;
    logic [LC_W-1:0] long_cnt;
    logic [SC_W-1:0] starve_cnt, starve_nxt;
    logic            rs1_pend, rs2_pend, rd_pend, fire;
    wb_req_t         wd, wd_nxt;

    cl2_pl_exu_scoreboard u_sb (
        .clk      (clk_i),
        .rst      (rst_i),
        .set_en   (fire & iss_rd_wen_i),
        .set_idx  (iss_rd_idx_i),
        .clr_en   (wd.wen),
        .clr_idx  (wd.idx),
        .rs1_idx  (iss_rs1_idx_i),
        .rs2_idx  (iss_rs2_idx_i),
        .rd_idx   (iss_rd_idx_i),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .rd_pend  (rd_pend)
    );

    assign iss_ready_o = !(rs1_pend | rs2_pend | (iss_rd_wen_i & rd_pend)
                         | (iss_long_i & (long_cnt == LC_W'(LONG_OUTST)))
                         | (state == ARB_BLOCK));
    assign fire           = iss_valid_i & iss_ready_o;
    assign lsu_wb_ready_o = lsu_wb_valid_i & !alu_wb_valid_i;

    // x0 results are consumed but never written
    always_comb begin
        wd_nxt = alu_wb_valid_i ? wb_req_t'{wen: alu_wb_idx_i != '0, idx: alu_wb_idx_i, dat: alu_wb_dat_i}
               : lsu_wb_ready_o ? wb_req_t'{wen: lsu_wb_idx_i != '0, idx: lsu_wb_idx_i, dat: lsu_wb_dat_i}
               : wb_req_t'{wen: 1'b0, idx: wd.idx, dat: wd.dat};
    end

    // BLOCK stops new ALU issue so the following LSU cycle is guaranteed free
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        case (state)
            ARB_NORM: begin
                starve_nxt = (lsu_wb_valid_i & !lsu_wb_ready_o) ? starve_cnt + 1'b1 : '0;
                state_nxt  = (starve_nxt == SC_W'(STARVE_MAX)) ? ARB_BLOCK : ARB_NORM;
            end
            ARB_BLOCK: state_nxt = ARB_LSU;
            default: begin
                state_nxt  = ARB_NORM;
                starve_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ARB_NORM;
            starve_cnt <= '0;
            long_cnt   <= '0;
            wd         <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            long_cnt   <= long_cnt + LC_W'(fire & iss_long_i) - LC_W'(lsu_wb_ready_o);
            wd         <= wd_nxt;
        end
    end

    assign wd_wen_o = wd.wen;
    assign wd_idx_o = wd.idx;
    assign wd_dat_o = wd.dat;

    a_no_alu_in_lsu_slot: assert property (@(posedge clk_i) disable iff (rst_i)
        state == ARB_LSU |-> !alu_wb_valid_i);
    a_lsu_hold: assert property (@(posedge clk_i)
        !rst_i && lsu_wb_valid_i && !lsu_wb_ready_o |=> lsu_wb_valid_i || rst_i);
endmodule

// File: tb/tb_cl2_pl_exu_wb_ctrl.sv
// tb_cl2_pl_exu_wb_ctrl: directed vectors for the write-back controller
module tb_cl2_pl_exu_wb_ctrl;
    import cl2_pl_exu_pkg::*;

    logic             clk_i = 1'b0, rst_i = 1'b1;
    logic             iss_valid_i, iss_ready_o, iss_rd_wen_i, iss_long_i;
    logic [REG_W-1:0] iss_rs1_idx_i, iss_rs2_idx_i, iss_rd_idx_i;
    logic             alu_wb_valid_i, lsu_wb_valid_i, lsu_wb_ready_o, wd_wen_o;
    logic [REG_W-1:0] alu_wb_idx_i, lsu_wb_idx_i, wd_idx_o;
    logic [XLEN-1:0]  alu_wb_dat_i, lsu_wb_dat_i, wd_dat_o;
    int checks = 0, failures = 0;

    cl2_pl_exu_wb_ctrl #(.STARVE_MAX(4), .LONG_OUTST(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .iss_valid_i(iss_valid_i), .iss_ready_o(iss_ready_o),
        .iss_rs1_idx_i(iss_rs1_idx_i), .iss_rs2_idx_i(iss_rs2_idx_i),
        .iss_rd_wen_i(iss_rd_wen_i), .iss_rd_idx_i(iss_rd_idx_i), .iss_long_i(iss_long_i),
        .alu_wb_valid_i(alu_wb_valid_i), .alu_wb_idx_i(alu_wb_idx_i), .alu_wb_dat_i(alu_wb_dat_i),
        .lsu_wb_valid_i(lsu_wb_valid_i), .lsu_wb_ready_o(lsu_wb_ready_o),
        .lsu_wb_idx_i(lsu_wb_idx_i), .lsu_wb_dat_i(lsu_wb_dat_i),
        .wd_wen_o(wd_wen_o), .wd_idx_o(wd_idx_o), .wd_dat_o(wd_dat_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        iss_valid_i = 0; iss_long_i = 0; iss_rd_wen_i = 0;
        iss_rs1_idx_i = 0; iss_rs2_idx_i = 0; iss_rd_idx_i = 0;
        alu_wb_valid_i = 0; alu_wb_idx_i = 0; alu_wb_dat_i = 0;
        lsu_wb_valid_i = 0; lsu_wb_idx_i = 0; lsu_wb_dat_i = 0;
    endtask

    task automatic iss(input logic v, input logic lng, input logic wen,
                       input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1);
        iss_valid_i = v; iss_long_i = lng; iss_rd_wen_i = wen;
        iss_rd_idx_i = rd; iss_rs1_idx_i = rs1; iss_rs2_idx_i = 0;
    endtask

    task automatic alu(input logic [REG_W-1:0] idx, input logic [XLEN-1:0] dat);
        alu_wb_valid_i = 1; alu_wb_idx_i = idx; alu_wb_dat_i = dat;
    endtask

    task automatic lsu(input logic [REG_W-1:0] idx, input logic [XLEN-1:0] dat);
        lsu_wb_valid_i = 1; lsu_wb_idx_i = idx; lsu_wb_dat_i = dat;
    endtask

    task automatic wd(input string tag, input logic wen, input logic [REG_W-1:0] idx, input logic [XLEN-1:0] dat);
        check({tag, "_wen"}, wd_wen_o, wen);
        if (wen) begin
            check({tag, "_idx"}, wd_idx_o, idx);
            check({tag, "_dat"}, wd_dat_o, dat);
        end
    endtask

    initial begin
        idle();
        tick(); tick();
        rst_i = 0; #1;
        check("rst_wen", wd_wen_o, 0);
        check("rst_idx", wd_idx_o, 0);
        check("rst_dat", wd_dat_o, 0);
        check("rst_iss_ready", iss_ready_o, 1);
        check("rst_lsu_ready", lsu_wb_ready_o, 0);

        // ALU write of x5 and RAW on it
        tick(); idle(); iss(1, 0, 1, 5, 0); #1;
        check("t1_fire", iss_ready_o, 1);
        tick(); idle(); alu(5, 32'hA5); iss(0, 0, 0, 0, 5); #1;
        check("t1_raw_a", iss_ready_o, 0);
        tick(); idle(); iss(0, 0, 0, 0, 5); #1;
        wd("t1_wd", 1, 5, 32'hA5);
        check("t1_raw_b", iss_ready_o, 0);
        tick(); idle(); iss(0, 0, 0, 0, 5); #1;
        check("t1_wen_1cyc", wd_wen_o, 0);
        check("t1_raw_clr", iss_ready_o, 1);

        // long op x3, dependent stalls until 2 cycles after the LSU grant
        tick(); idle(); iss(1, 1, 1, 3, 0); #1;
        check("t2_fire", iss_ready_o, 1);
        tick(); idle(); iss(0, 0, 0, 0, 3); lsu(3, 32'h33); #1;
        check("t2_raw_a", iss_ready_o, 0);
        check("t2_lsu_gnt", lsu_wb_ready_o, 1);
        tick(); idle(); iss(0, 0, 0, 0, 3); #1;
        check("t2_raw_b", iss_ready_o, 0);
        wd("t2_wd", 1, 3, 32'h33);
        tick(); idle(); iss(0, 0, 0, 0, 3); #1;
        check("t2_raw_clr", iss_ready_o, 1);

        // long outstanding limit
        tick(); idle(); iss(1, 1, 1, 10, 0); #1;
        check("t4_long0", iss_ready_o, 1);
        tick(); idle(); iss(1, 1, 1, 11, 0); #1;
        check("t4_long1", iss_ready_o, 1);
        tick(); idle(); iss(1, 1, 1, 12, 0); #1;
        check("t4_long_full", iss_ready_o, 0);
        iss(1, 0, 1, 12, 0); #1;
        check("t4_short_ok", iss_ready_o, 1);
        tick(); idle(); alu(12, 32'hC); #1;
        tick(); idle(); lsu(10, 32'h10); #1;
        wd("t4_wd12", 1, 12, 32'hC);
        check("t4_lsu10_gnt", lsu_wb_ready_o, 1);
        tick(); idle(); lsu(11, 32'h11); #1;
        wd("t4_wd10", 1, 10, 32'h10);
        tick(); idle(); #1;
        wd("t4_wd11", 1, 11, 32'h11);
        tick(); idle(); iss(0, 1, 1, 12, 11); #1;
        check("t4_drained", iss_ready_o, 1);

        // x0 results never write and never set pending
        tick(); idle(); iss(1, 0, 1, 0, 0); #1;
        check("t5_fire", iss_ready_o, 1);
        tick(); idle(); alu(0, 32'hFFFF_FFFF); iss(1, 1, 1, 0, 0); #1;
        check("t5_no_pend", iss_ready_o, 1);
        tick(); idle(); lsu(0, 32'h1); #1;
        check("t5_alu_x0", wd_wen_o, 0);
        check("t5_lsu_gnt", lsu_wb_ready_o, 1);
        tick(); idle(); #1;
        check("t5_lsu_x0", wd_wen_o, 0);

        // LSU starvation behind a continuous ALU stream
        tick(); idle(); iss(1, 1, 1, 9, 0); #1;
        tick(); idle(); iss(1, 0, 1, 20, 0); #1;
        for (int i = 1; i <= 4; i++) begin
            tick(); idle(); iss(1, 0, 1, REG_W'(20 + i), 0); alu(REG_W'(19 + i), XLEN'(i)); lsu(9, 32'h99); #1;
            check($sformatf("t3_lose%0d", i), lsu_wb_ready_o, 0);
            check($sformatf("t3_iss%0d", i), iss_ready_o, 1);
        end
        tick(); idle(); iss(1, 0, 1, 25, 0); alu(24, 32'h4); lsu(9, 32'h99); #1;
        check("t3_block_iss", iss_ready_o, 0);
        check("t3_block_lsu", lsu_wb_ready_o, 0);
        tick(); idle(); lsu(9, 32'h99); #1;
        check("t3_lsu_slot", lsu_wb_ready_o, 1);
        check("t3_lsu_slot_iss", iss_ready_o, 1);
        wd("t3_wd24", 1, 24, 32'h4);
        tick(); idle(); #1;
        wd("t3_wd9", 1, 9, 32'h99);

        // reset mid-operation
        tick(); idle(); iss(1, 1, 1, 7, 0); #1;
        tick(); idle(); iss(1, 1, 1, 6, 0); #1;
        tick(); idle(); iss(1, 0, 1, 8, 0); #1;
        tick(); idle(); alu(8, 32'h8); lsu(7, 32'h77); iss(0, 1, 0, 0, 7); #1;
        check("t6_lsu_stall", lsu_wb_ready_o, 0);
        check("t6_pre_iss", iss_ready_o, 0);
        tick(); idle(); rst_i = 1; #1;
        wd("t6_pre_wd", 1, 8, 32'h8);
        tick(); idle(); rst_i = 0; iss(0, 1, 1, 8, 7); #1;
        check("t6_iss_ready", iss_ready_o, 1);
        check("t6_wen", wd_wen_o, 0);
        check("t6_idx", wd_idx_o, 0);
        check("t6_dat", wd_dat_o, 0);
        check("t6_lsu_ready", lsu_wb_ready_o, 0);
        tick(); idle(); #1;
        check("t6_no_write", wd_wen_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
